uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Parametrised successor to the team's single-word UART transmitter.
- Buffers words in an internal FIFO.
- Serialises each word LSB-first with a configurable data width, parity mode and stop-bit count.
- Paces every bit from an external baud tick (tx_en) produced by the shared baud generator.
- Sits between the command/data path and the tx pin; back-to-back frames are sent with no idle gap while the FIFO holds data.

Parameters:
DATA_BITS, 7, data bits per frame; legal 5..9.
PARITY, 2, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; legal 1 or 2.
FIFO_DEPTH, 4, word capacity; power of two, >= 2.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-high reset.
tx_en  input  1  baud tick, one clk cycle wide; one tick = one bit period.
data_in  input  DATA_BITS  word to enqueue.
start  input  1  write strobe; enqueues data_in when wr_ready=1.
wr_ready  output  1  FIFO not full.
fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently queued.
overflow  output  1  sticky: a start was seen while wr_ready=0.
busy  output  1  frame in progress or FIFO non-empty.
tx  output  1  serial line, idle high.

Behaviour:
- Reset (async, any time including mid-frame): tx=1, state=IDLE, FIFO emptied, fifo_count=0, wr_ready=1, overflow=0, busy=0.
- FIFO write: start=1 and wr_ready=1 at a clk edge stores data_in.
- FIFO full: start=1 with wr_ready=0 drops the word and sets overflow, which stays set until reset.
- wr_ready = (fifo_count != FIFO_DEPTH), evaluated on registered state.
- No write-to-pop bypass: a word written in cycle N can be popped at the earliest in cycle N+1.
- Simultaneous write and pop in the same cycle: both take effect, fifo_count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Frame slots, each exactly one tick interval: START(0), DATA[0]..DATA[DATA_BITS-1], PARITY (only if PARITY!=0), STOP x STOP_BITS (1).
- Parity bit: even = XOR of data bits; odd = XNOR of data bits.
- tx is registered and changes only on cycles where tx_en=1. State and bit index advance only on those cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE, tick, fifo_count>0: pop head into shift register, tx<=0, go to START.
  - IDLE, tick, FIFO empty: hold, tx=1.
  - IDLE, no tick: hold.
  - START, tick: tx<=bit0, go to DATA with idx=1.
  - DATA, tick: if idx<DATA_BITS, tx<=bit[idx] and idx++. Otherwise tx<=parity and go to PARITY, or, when PARITY=0, tx<=1 and go to STOP with scnt=1.
  - PARITY, tick: tx<=1, go to STOP with scnt=1.
  - STOP, tick, scnt<STOP_BITS: tx<=1, scnt++.
  - STOP, tick, scnt==STOP_BITS, FIFO non-empty: pop, tx<=0, go to START (back-to-back, no gap).
  - STOP, tick, scnt==STOP_BITS, FIFO empty: tx stays 1, go to IDLE.
- busy = (state!=IDLE) || (fifo_count!=0). busy falls in the cycle after the final stop-bit slot's ending tick, when the FIFO is empty.
- start, tx_en and the FIFO contents do not alter the word being shifted; it is latched at pop.
- tx_en held high continuously gives one bit per clk cycle and must be supported.

Test Plan:
- Defaults, tx_en every 4 clk, one write of 7'h41:
  - tx = 0,1,0,0,0,0,0,1,1(parity),1, each bit 4 clk.
  - busy high from the write until the final stop slot ends, then low; fifo_count returns to 0.
- DATA_BITS=8, PARITY=1, STOP_BITS=2, write 8'hA5:
  - frame 0,1,0,1,0,0,1,0,1,0(parity),1,1 = 12 slots.
- Defaults, write 3 words in consecutive cycles:
  - frames back-to-back; the start bit of the next frame follows the stop bit with no extra idle slot.
  - 30 bit periods total.
- FIFO_DEPTH=4, tx_en held low, write 5 words:
  - wr_ready drops after the 4th write; 5th word dropped; overflow=1.
  - After ticks resume, exactly 4 frames are sent.
- Assert reset during the DATA slot of bit 3:
  - tx=1 asynchronously, busy=0, fifo_count=0, overflow=0.
  - After release, a new write produces a clean full frame.
- tx_en tied high, one write with start and tx_en in the same cycle:
  - pop occurs the following cycle; frame bits are one clk each.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input word FIFO, configurable data width, parity and stop bits.
// Bit timing is driven entirely by the external baud tick tx_en.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 7,
    parameter int PARITY     = 2,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_en,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          start,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic ODD = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic [CW-1:0]        count;
    logic                 push, pop;
    logic [DATA_BITS-1:0] shreg_q, shreg_d, shifted;
    logic [IW-1:0]        idx_q, idx_d;
    logic [1:0]           scnt_q, scnt_d;
    logic                 tx_q, tx_d, par;

    assign wr_ready   = (count != CW'(FIFO_DEPTH));
    assign push       = start & wr_ready;
    assign fifo_count = count;
    assign busy       = (state_q != S_IDLE) || (count != '0);
    assign tx         = tx_q;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (!push && pop)
                count <= count - CW'(1);
            if (start && !wr_ready)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            scnt_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            scnt_q  <= scnt_d;
            tx_q    <= tx_d;
        end
    end

    assign shifted = shreg_q >> idx_q;
    assign par     = (^shreg_q) ^ ODD;

    // Pop only reads registered FIFO state, so a word written this cycle is never bypassed.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        scnt_d  = scnt_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (tx_en) begin
            case (state_q)
                S_IDLE: begin
                    tx_d = 1'b1;
                    if (count != '0) begin
                        pop     = 1'b1;
                        shreg_d = mem[rptr];
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    tx_d    = shreg_q[0];
                    idx_d   = IW'(1);
                    state_d = S_DATA;
                end
                S_DATA: begin
                    if (idx_q < IW'(DATA_BITS)) begin
                        tx_d  = shifted[0];
                        idx_d = idx_q + IW'(1);
                    end else if (PARITY != 0) begin
                        tx_d    = par;
                        state_d = S_PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        scnt_d  = 2'd1;
                        state_d = S_STOP;
                    end
                end
                S_PARITY: begin
                    tx_d    = 1'b1;
                    scnt_d  = 2'd1;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    tx_d = 1'b1;
                    if (scnt_q < 2'(STOP_BITS)) begin
                        scnt_d = scnt_q + 2'd1;
                    end else if (count != '0) begin
                        pop     = 1'b1;
                        shreg_d = mem[rptr];
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end
endmodule
